controlador_dht11: RTL and testbench
====================================

Name: controlador_dht11

Overview:
- Sequences the DHT11 communication block for the command path: accepts a read request, enforces sensor hold-off, and drives `enable_sensor`.
- Waits for `done`, validates the checksum and retries on failure.
- Returns a 16-bit humidity or temperature word with a status code over a valid/ready response channel.
- Sits between the command decoder (UART side) and the DHT11 communication instance; runs on the 50 MHz system clock.

Parameters:
- HOLDOFF_CYCLES, 100_000_000, minimum gap from `enable_sensor` falling to the next rising (2 s at 50 MHz).
- TIMEOUT_CYCLES, 15_000_000, maximum wait for synchronized done after `enable_sensor` rises.
- RELEASE_CYCLES, 100, minimum low time of `enable_sensor` after each attempt.
- MAX_RETRIES, 2, extra attempts after a failed first attempt.

Ports:
- clock  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_cmd  in  2  00 = humidity, 01 = temperature, 10/11 = invalid
- req_ready  out  1  controller can accept a request
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_code  out  8  00 OK, E1 sensor error, E2 checksum error, E3 timeout, E4 invalid command
- resp_data  out  16  reading; 0 unless resp_code = 00
- enable_sensor  out  1  to the DHT11 block; low clears it asynchronously
- dados_sensor  in  40  sensor frame {hum_int, hum_dec, temp_int, temp_dec, checksum}
- erro  in  1  sensor error flag
- done  in  1  sensor completion, level, held until `enable_sensor` low

Behaviour:
- Reset values: `req_ready` = 0, `resp_valid` = 0, `resp_code` = 00, `resp_data` = 0, `enable_sensor` = 0.
- Reset clears the retry count and the latched command. It loads the hold-off counter with 0, so a full HOLDOFF_CYCLES must elapse after reset before the first enable.
- `done` passes through a 2-flop synchronizer (done_s). `erro` and `dados_sensor` are sampled one cycle after done_s first reads 1.
- Hold-off counter: free-running saturating count. It restarts at 0 on every `enable_sensor` 1->0 transition. "Expired" means count >= HOLDOFF_CYCLES.

State machine:
- IDLE: `req_ready` = 1. On `req_valid` & `req_ready`, latch `req_cmd`, clear the retry count, and set `req_ready` = 0 the next cycle.
  - cmd >= 10 -> RESPOND with E4, no sensor access.
  - otherwise -> HOLDOFF.
- HOLDOFF: wait until expired -> START.
- START: `enable_sensor` = 1, clear the timeout counter -> WAIT_DONE.
- WAIT_DONE: on done_s = 1 -> CHECK. If timeout counter = TIMEOUT_CYCLES - 1 first -> result E3 -> RELEASE.
- CHECK (1 cycle):
  - `erro` = 1 -> E1.
  - else if (b4 + b3 + b2 + b1) mod 256 != b0 -> E2.
  - else OK: data = {b4,b3} for cmd 00, {b2,b1} for cmd 01.
  - Then -> RELEASE.
- RELEASE: `enable_sensor` = 0 for RELEASE_CYCLES.
  - Result OK -> RESPOND.
  - Error with retry count < MAX_RETRIES -> increment retry count -> HOLDOFF.
  - Error with retries exhausted -> RESPOND with the last error code.
- RESPOND: `resp_valid` = 1 with `resp_code`/`resp_data` stable until `resp_valid` & `resp_ready`; then -> IDLE the next cycle with `resp_valid` = 0.
- `resp_ready` held high: `resp_valid` is a 1-cycle pulse.

Constraints and boundary cases:
- `enable_sensor` never rises in any state except START, and never while the hold-off counter has not expired.
- Checksum sum is computed in 8 bits; wrap-around is intended (FF+01+00+00 = 00).
- done_s and timeout expiry in the same cycle: done wins.
- `req_valid` while busy is ignored (`req_ready` = 0); the requester holds it.
- `resp_ready` low in RESPOND: outputs are held indefinitely; no sensor activity.
- reset_n low mid-attempt: `enable_sensor` drops immediately (async), which aborts the sensor block. On release, the full hold-off applies.

Test Plan:
- Reset, then cmd 00; model returns done after 5 ms with frame 0x3700_1A00_51, `erro` = 0 -> `enable_sensor` rises no earlier than 100_000_000 cycles after reset; `resp_code` 00, `resp_data` 0x3700.
- Back-to-back cmd 01 after a response -> second enable rises >= HOLDOFF_CYCLES after the first enable fell; `resp_data` 0x1A00.
- Frame 0x3700_1A00_52 on every attempt -> exactly 3 enable pulses, each low >= RELEASE_CYCLES; `resp_code` E2, `resp_data` 0.
- Model asserts `erro` + `done` on attempt 1 and returns a good frame 0xFF01_0000_00 on attempt 2 -> `resp_code` 00 (wrap-around checksum); data 0xFF01 for cmd 00.
- `done` never asserted -> each attempt lasts TIMEOUT_CYCLES; 3 attempts; `resp_code` E3. cmd 11 -> E4 within 3 cycles, `enable_sensor` stays 0.
- `resp_ready` = 0 for 1000 cycles in RESPOND -> `resp_valid`/`resp_code`/`resp_data` stable. Pulse reset_n low during WAIT_DONE -> `enable_sensor` 0 in the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/controlador_dht11_if.sv
// Command/response channel between the UART command decoder and the DHT11 controller.
// The decoder is the master; the controller is the slave.
interface controlador_dht11_if;
    logic        req_valid;
    logic [1:0]  req_cmd;
    logic        req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_code;
    logic [15:0] resp_data;

    modport master (
        output req_valid, req_cmd, resp_ready,
        input  req_ready, resp_valid, resp_code, resp_data
    );

    modport slave (
        input  req_valid, req_cmd, resp_ready,
        output req_ready, resp_valid, resp_code, resp_data
    );
endinterface

// File: rtl/controlador_dht11.sv
// DHT11 read sequencer: hold-off, enable pulse, done/timeout wait, checksum check,
// bounded retries and a valid/ready response with a status code.
module controlador_dht11 #(
    parameter int unsigned HOLDOFF_CYCLES = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 15_000_000,
    parameter int unsigned RELEASE_CYCLES = 100,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    controlador_dht11_if.slave  cmd_if,
    output logic                enable_sensor,
    input  logic [39:0]         dados_sensor,
    input  logic                erro,
    input  logic                done
);

    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
    localparam int unsigned NW = $clog2(MAX_RETRIES + 2);

    localparam logic [7:0] CodeOk       = 8'h00;
    localparam logic [7:0] CodeSensor   = 8'hE1;
    localparam logic [7:0] CodeChecksum = 8'hE2;
    localparam logic [7:0] CodeTimeout  = 8'hE3;
    localparam logic [7:0] CodeInvalid  = 8'hE4;

    typedef enum logic [2:0] {
        StIdle,
        StHoldoff,
        StStart,
        StWaitDone,
        StCheck,
        StRelease,
        StRespond
    } state_e;

    state_e        state_q, state_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [7:0]    resp_code_q, resp_code_d;
    logic [15:0]   resp_data_q, resp_data_d;
    logic          en_q, en_d;
    logic          temp_sel_q, temp_sel_d;
    logic [NW-1:0] retry_q, retry_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] rel_q, rel_d;
    logic [HW-1:0] holdoff_cnt_q, holdoff_cnt_d;
    logic [7:0]    res_code_q, res_code_d;
    logic [15:0]   res_data_q, res_data_d;
    logic          done_meta_q, done_s_q;

    logic          holdoff_expired;
    logic [7:0]    b4, b3, b2, b1, b0;
    logic [7:0]    sum8;

    assign holdoff_expired = (holdoff_cnt_q >= HW'(HOLDOFF_CYCLES));

    assign b4 = dados_sensor[39:32];
    assign b3 = dados_sensor[31:24];
    assign b2 = dados_sensor[23:16];
    assign b1 = dados_sensor[15:8];
    assign b0 = dados_sensor[7:0];
    // 8-bit sum: wrap-around is part of the DHT11 checksum definition.
    assign sum8 = b4 + b3 + b2 + b1;

    assign cmd_if.req_ready  = req_ready_q;
    assign cmd_if.resp_valid = resp_valid_q;
    assign cmd_if.resp_code  = resp_code_q;
    assign cmd_if.resp_data  = resp_data_q;
    assign enable_sensor     = en_q;

    always_comb begin
        state_d       = state_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_code_d   = resp_code_q;
        resp_data_d   = resp_data_q;
        en_d          = en_q;
        temp_sel_d    = temp_sel_q;
        retry_d       = retry_q;
        tmo_d         = tmo_q;
        rel_d         = rel_q;
        res_code_d    = res_code_q;
        res_data_d    = res_data_q;
        holdoff_cnt_d = holdoff_cnt_q;

        unique case (state_q)
            StIdle: begin
                req_ready_d = 1'b1;
                if (cmd_if.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    temp_sel_d  = cmd_if.req_cmd[0];
                    retry_d     = '0;
                    if (cmd_if.req_cmd[1]) begin
                        state_d      = StRespond;
                        resp_valid_d = 1'b1;
                        resp_code_d  = CodeInvalid;
                        resp_data_d  = '0;
                    end else begin
                        state_d = StHoldoff;
                    end
                end
            end
            StHoldoff: begin
                if (holdoff_expired) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                en_d    = 1'b1;
                tmo_d   = '0;
                state_d = StWaitDone;
            end
            StWaitDone: begin
                // done is tested first so it wins over a coincident timeout
                if (done_s_q) begin
                    state_d = StCheck;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    res_code_d = CodeTimeout;
                    res_data_d = '0;
                    en_d       = 1'b0;
                    rel_d      = '0;
                    state_d    = StRelease;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StCheck: begin
                en_d       = 1'b0;
                rel_d      = '0;
                state_d    = StRelease;
                res_data_d = '0;
                if (erro) begin
                    res_code_d = CodeSensor;
                end else if (sum8 != b0) begin
                    res_code_d = CodeChecksum;
                end else begin
                    res_code_d = CodeOk;
                    res_data_d = temp_sel_q ? {b2, b1} : {b4, b3};
                end
            end
            StRelease: begin
                if (rel_q == RW'(RELEASE_CYCLES - 1)) begin
                    if (res_code_q == CodeOk || retry_q >= NW'(MAX_RETRIES)) begin
                        state_d      = StRespond;
                        resp_valid_d = 1'b1;
                        resp_code_d  = res_code_q;
                        resp_data_d  = res_data_q;
                    end else begin
                        retry_d = retry_q + NW'(1);
                        state_d = StHoldoff;
                    end
                end else begin
                    rel_d = rel_q + RW'(1);
                end
            end
            StRespond: begin
                if (cmd_if.resp_ready) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Saturating hold-off count, restarted by each falling edge of the enable.
        if (!holdoff_expired) begin
            holdoff_cnt_d = holdoff_cnt_q + HW'(1);
        end
        if (en_q && !en_d) begin
            holdoff_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            resp_code_q   <= 8'h00;
            resp_data_q   <= '0;
            en_q          <= 1'b0;
            temp_sel_q    <= 1'b0;
            retry_q       <= '0;
            tmo_q         <= '0;
            rel_q         <= '0;
            holdoff_cnt_q <= '0;
            res_code_q    <= 8'h00;
            res_data_q    <= '0;
            done_meta_q   <= 1'b0;
            done_s_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_code_q   <= resp_code_d;
            resp_data_q   <= resp_data_d;
            en_q          <= en_d;
            temp_sel_q    <= temp_sel_d;
            retry_q       <= retry_d;
            tmo_q         <= tmo_d;
            rel_q         <= rel_d;
            holdoff_cnt_q <= holdoff_cnt_d;
            res_code_q    <= res_code_d;
            res_data_q    <= res_data_d;
            done_meta_q   <= done;
            done_s_q      <= done_meta_q;
        end
    end

endmodule

// File: tb/tb_controlador_dht11.sv
// Self-checking bench for controlador_dht11: table vectors, randomized transactions against a
// reference model, response stall and mid-attempt reset sequences.
module tb_controlador_dht11;

    localparam int unsigned HOLDOFF = 200;
    localparam int unsigned TIMEOUT = 150;
    localparam int unsigned RELEASE = 10;
    localparam int unsigned MAXR    = 2;
    localparam int          BUDGET  = 3000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable_sensor;
    logic [39:0] dados_sensor;
    logic        erro;
    logic        done;

    controlador_dht11_if cmd_if ();

    controlador_dht11 #(
        .HOLDOFF_CYCLES(HOLDOFF),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RELEASE_CYCLES(RELEASE),
        .MAX_RETRIES   (MAXR)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd_if       (cmd_if),
        .enable_sensor(enable_sensor),
        .dados_sensor (dados_sensor),
        .erro         (erro),
        .done         (done)
    );

    always #10 clock = ~clock;

    int check_cnt = 0;
    int pass_cnt  = 0;

    // Per-attempt sensor behaviour; delay 0 means done never rises.
    logic [39:0] att_frame [3];
    bit          att_erro  [3];
    int          att_delay [3];
    int          pulse_cnt;
    int          low_cnt;
    int          high_cnt;
    int          att_idx;
    bit          en_prev;

    typedef struct packed {
        logic [1:0]       cmd;
        logic [2:0][39:0] frame;
        logic [2:0]       erro;
        logic [2:0][7:0]  delay;
        logic [7:0]       code;
        logic [15:0]      data;
        logic [3:0]       pulses;
    } vec_t;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    task automatic chk_true(input string name, input bit ok, input int act, input int bound);
        check_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d bound %0d", name, act, bound);
    endtask

    // Sensor model plus enable-timing monitor, both sampled on the falling edge.
    initial begin
        done = 1'b0; erro = 1'b0; dados_sensor = '0;
        en_prev = 1'b0; low_cnt = 0; high_cnt = 0; pulse_cnt = 0; att_idx = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                low_cnt = 0; high_cnt = 0; en_prev = 1'b0; done = 1'b0; erro = 1'b0;
            end else if (enable_sensor) begin
                if (!en_prev) begin
                    chk_true("holdoff_gap", low_cnt >= HOLDOFF, low_cnt, HOLDOFF);
                    att_idx = (pulse_cnt > 2) ? 2 : pulse_cnt;
                    pulse_cnt++;
                    high_cnt = 0;
                end
                high_cnt++;
                if (att_delay[att_idx] != 0 && high_cnt >= att_delay[att_idx]) begin
                    done = 1'b1;
                    erro = att_erro[att_idx];
                    dados_sensor = att_frame[att_idx];
                end
                en_prev = 1'b1;
            end else begin
                if (en_prev) begin
                    low_cnt = 0;
                    if (att_delay[att_idx] == 0)
                        chk_true("timeout_len", high_cnt >= TIMEOUT && high_cnt <= TIMEOUT + 1,
                                 high_cnt, TIMEOUT);
                end
                done = 1'b0; erro = 1'b0;
                low_cnt++;
                en_prev = 1'b0;
            end
        end
    end

    // Expected outcome from the retry rules, evaluated attempt by attempt.
    task automatic ref_model(input logic [1:0] cmd, output logic [7:0] code,
                             output logic [15:0] data, output int pulses);
        logic [7:0] s;
        code = 8'h00; data = 16'h0; pulses = 0;
        if (cmd >= 2'd2) begin
            code = 8'hE4;
            return;
        end
        for (int a = 0; a <= int'(MAXR); a++) begin
            pulses = a + 1;
            s = att_frame[a][39:32] + att_frame[a][31:24] + att_frame[a][23:16]
                + att_frame[a][15:8];
            if (att_delay[a] == 0) code = 8'hE3;
            else if (att_erro[a]) code = 8'hE1;
            else if (s != att_frame[a][7:0]) code = 8'hE2;
            else begin
                code = 8'h00;
                data = (cmd == 2'd1) ? att_frame[a][23:8] : att_frame[a][39:24];
                return;
            end
        end
        data = 16'h0;
    endtask

    task automatic send_req(input logic [1:0] cmd, output bit ok);
        int n = 0;
        while (cmd_if.req_ready !== 1'b1 && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        ok = (cmd_if.req_ready === 1'b1);
        if (!ok) begin
            chk_true("req_ready_wait", 1'b0, n, BUDGET);
            return;
        end
        pulse_cnt = 0;
        cmd_if.req_cmd   = cmd;
        cmd_if.req_valid = 1'b1;
        @(negedge clock);
        cmd_if.req_valid = 1'b0;
        chk("req_ready_busy", cmd_if.req_ready, 1'b0);
    endtask

    task automatic run_txn(input logic [1:0] cmd, output bit got, output int lat);
        bit ok;
        got = 1'b0;
        lat = 0;
        send_req(cmd, ok);
        if (!ok) return;
        lat = 1;
        while (cmd_if.resp_valid !== 1'b1 && lat < BUDGET) begin
            @(negedge clock);
            lat++;
        end
        got = (cmd_if.resp_valid === 1'b1);
        if (!got) chk_true("resp_wait", 1'b0, lat, BUDGET);
    endtask

    task automatic load_vec(input vec_t v);
        for (int a = 0; a < 3; a++) begin
            att_frame[a] = v.frame[a];
            att_erro[a]  = v.erro[a];
            att_delay[a] = int'(v.delay[a]);
        end
    endtask

    function automatic logic [39:0] good_frame(input logic [31:0] w);
        logic [7:0] s;
        s = w[31:24] + w[23:16] + w[15:8] + w[7:0];
        return {w, s};
    endfunction

    vec_t        vecs [9];
    bit          got;
    int          lat;
    logic [7:0]  e_code;
    logic [15:0] e_data;
    int          e_pulses;
    logic [7:0]  h_code;
    logic [15:0] h_data;
    bit          stable;
    int          n;

    initial begin
        cmd_if.req_valid  = 1'b0;
        cmd_if.req_cmd    = 2'd0;
        cmd_if.resp_ready = 1'b1;
        for (int a = 0; a < 3; a++) begin
            att_frame[a] = '0; att_erro[a] = 1'b0; att_delay[a] = 20;
        end

        vecs[0] = '{cmd: 2'd0, frame: {3{40'h37001A0051}}, erro: 3'b000, delay: {3{8'd20}},
                    code: 8'h00, data: 16'h3700, pulses: 4'd1};
        vecs[1] = '{cmd: 2'd1, frame: {3{40'h37001A0051}}, erro: 3'b000, delay: {3{8'd20}},
                    code: 8'h00, data: 16'h1A00, pulses: 4'd1};
        vecs[2] = '{cmd: 2'd0, frame: {3{40'h37001A0052}}, erro: 3'b000, delay: {3{8'd25}},
                    code: 8'hE2, data: 16'h0000, pulses: 4'd3};
        vecs[3] = '{cmd: 2'd0, frame: {40'h0, 40'hFF01000000, 40'h37001A0051}, erro: 3'b001,
                    delay: {8'd20, 8'd30, 8'd20}, code: 8'h00, data: 16'hFF01, pulses: 4'd2};
        vecs[4] = '{cmd: 2'd0, frame: {3{40'h37001A0051}}, erro: 3'b000, delay: {3{8'd0}},
                    code: 8'hE3, data: 16'h0000, pulses: 4'd3};
        vecs[5] = '{cmd: 2'd3, frame: {3{40'h37001A0051}}, erro: 3'b000, delay: {3{8'd20}},
                    code: 8'hE4, data: 16'h0000, pulses: 4'd0};
        vecs[6] = '{cmd: 2'd2, frame: {3{40'h37001A0051}}, erro: 3'b000, delay: {3{8'd20}},
                    code: 8'hE4, data: 16'h0000, pulses: 4'd0};
        vecs[7] = '{cmd: 2'd1, frame: {3{40'h37001A0051}}, erro: 3'b111, delay: {3{8'd15}},
                    code: 8'hE1, data: 16'h0000, pulses: 4'd3};
        vecs[8] = '{cmd: 2'd1, frame: {40'h11223344AA, 40'h11223344AB, 40'h0}, erro: 3'b000,
                    delay: {8'd60, 8'd40, 8'd0}, code: 8'h00, data: 16'h3344, pulses: 4'd3};

        #1 reset_n = 1'b0;
        #3;
        chk("rst_req_ready", cmd_if.req_ready, 1'b0);
        chk("rst_resp_valid", cmd_if.resp_valid, 1'b0);
        chk("rst_resp_code", cmd_if.resp_code, 8'h00);
        chk("rst_resp_data", cmd_if.resp_data, 16'h0);
        chk("rst_enable", enable_sensor, 1'b0);
        #51 reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            load_vec(vecs[i]);
            run_txn(vecs[i].cmd, got, lat);
            if (got) begin
                chk($sformatf("vec%0d_code", i), cmd_if.resp_code, vecs[i].code);
                chk($sformatf("vec%0d_data", i), cmd_if.resp_data, vecs[i].data);
                chk($sformatf("vec%0d_pulses", i), pulse_cnt, vecs[i].pulses);
                if (vecs[i].code == 8'hE4)
                    chk_true($sformatf("vec%0d_e4_latency", i), lat <= 3, lat, 3);
                @(negedge clock);
                chk($sformatf("vec%0d_resp_pulse", i), cmd_if.resp_valid, 1'b0);
            end
        end

        for (int r = 0; r < 8; r++) begin
            logic [1:0] cmd;
            cmd = 2'($urandom_range(0, 3));
            for (int a = 0; a < 3; a++) begin
                int kind;
                kind = $urandom_range(0, 5);
                att_frame[a] = good_frame($urandom);
                att_erro[a]  = 1'b0;
                att_delay[a] = $urandom_range(3, 100);
                if (kind == 3) att_frame[a][7:0] = att_frame[a][7:0] + 8'($urandom_range(1, 255));
                else if (kind == 4) att_erro[a] = 1'b1;
                else if (kind == 5) att_delay[a] = 0;
            end
            ref_model(cmd, e_code, e_data, e_pulses);
            run_txn(cmd, got, lat);
            if (got) begin
                chk($sformatf("rnd%0d_code", r), cmd_if.resp_code, e_code);
                chk($sformatf("rnd%0d_data", r), cmd_if.resp_data, e_data);
                chk($sformatf("rnd%0d_pulses", r), pulse_cnt, e_pulses);
                @(negedge clock);
            end
        end

        // Response stall: outputs must hold and the sensor must stay idle.
        load_vec(vecs[1]);
        cmd_if.resp_ready = 1'b0;
        run_txn(2'd1, got, lat);
        if (got) begin
            h_code = cmd_if.resp_code;
            h_data = cmd_if.resp_data;
            chk("stall_code", h_code, 8'h00);
            chk("stall_data", h_data, 16'h1A00);
            stable = 1'b1;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clock);
                if (cmd_if.resp_valid !== 1'b1 || cmd_if.resp_code !== h_code ||
                    cmd_if.resp_data !== h_data || enable_sensor !== 1'b0) stable = 1'b0;
            end
            chk("stall_stable", stable, 1'b1);
            cmd_if.resp_ready = 1'b1;
            @(negedge clock);
            @(negedge clock);
            chk("stall_release", cmd_if.resp_valid, 1'b0);
        end
        cmd_if.resp_ready = 1'b1;

        // Reset pulse during WAIT_DONE.
        load_vec(vecs[4]);
        send_req(2'd0, got);
        n = 0;
        while (enable_sensor !== 1'b1 && n < BUDGET) begin
            @(negedge clock);
            n++;
        end
        chk("midrst_enable_seen", enable_sensor, 1'b1);
        repeat (5) @(negedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_enable", enable_sensor, 1'b0);
        chk("midrst_req_ready", cmd_if.req_ready, 1'b0);
        chk("midrst_resp_valid", cmd_if.resp_valid, 1'b0);
        chk("midrst_resp_code", cmd_if.resp_code, 8'h00);
        chk("midrst_resp_data", cmd_if.resp_data, 16'h0);
        repeat (3) @(negedge clock);
        #5 reset_n = 1'b1;

        load_vec(vecs[0]);
        run_txn(2'd0, got, lat);
        if (got) begin
            chk("recover_code", cmd_if.resp_code, 8'h00);
            chk("recover_data", cmd_if.resp_data, 16'h3700);
            @(negedge clock);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
